// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALUOp values and the funct3 fields that matter to decode.
// Imported by the issue stage, its decoder and the ALU itself.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct decode into the 4-bit ALU control code plus branch kind.
// Branches with an unsupported funct3 keep the SUB code but are flagged illegal.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       is_rtype,
  output logic [3:0] code,
  output logic       illegal,
  output logic       is_beq,
  output logic       is_bne
);

  always_comb begin
    code    = ALU_ILL;
    illegal = 1'b1;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    case (alu_op)
      ALUOP_MEM: begin
        code    = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_BR: begin
        code    = ALU_SUB;
        is_beq  = (funct3 == F3_BEQ);
        is_bne  = (funct3 == F3_BNE);
        illegal = !(is_beq || is_bne);
      end
      ALUOP_RI: begin
        case (funct3)
          F3_ADD: begin
            code    = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            illegal = 1'b0;
          end
          F3_AND: begin
            code    = ALU_AND;
            illegal = 1'b0;
          end
          F3_OR: begin
            code    = ALU_OR;
            illegal = 1'b0;
          end
          default: begin
            code    = ALU_ILL;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        code    = ALU_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue stage: decodes and selects operands at capture, holds them in an out/skid pair,
// and resolves BEQ/BNE from the ALU zero flag one cycle after the op is taken.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_b5,
  input  logic             in_is_rtype,
  input  logic             in_alu_src,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control_lines,
  output logic [XLEN-1:0]  operand1,
  output logic [XLEN-1:0]  operand2,
  output logic             out_illegal,
  input  logic             zero,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [3:0]      code;
    logic            illegal;
    logic            is_beq;
    logic            is_bne;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } op_t;

  op_t  in_op, out_op, skid_op;
  logic skid_valid;
  logic [3:0] dec_code;
  logic dec_illegal, dec_beq, dec_bne;
  logic in_hs, out_hs, out_free;

  alu_ctrl_decode u_decode (
    .alu_op    (in_alu_op),
    .funct3    (in_funct3),
    .funct7_b5 (in_funct7_b5),
    .is_rtype  (in_is_rtype),
    .code      (dec_code),
    .illegal   (dec_illegal),
    .is_beq    (dec_beq),
    .is_bne    (dec_bne)
  );

  always_comb begin
    in_op         = '0;
    in_op.code    = dec_code;
    in_op.illegal = dec_illegal;
    in_op.is_beq  = dec_beq;
    in_op.is_bne  = dec_bne;
    in_op.op1     = in_rs1;
    in_op.op2     = in_alu_src ? in_imm : in_rs2;
  end

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign out_free = !out_valid || out_hs;

  // in_ready is low whenever skid holds an op, so skid drain and input capture never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_op     <= '0;
      skid_op    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_op     <= skid_op;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (in_hs) begin
        out_op    <= in_op;
        out_valid <= 1'b1;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end
    end else if (in_hs) begin
      skid_op    <= in_op;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

  assign alu_control_lines = out_op.code;
  assign operand1          = out_op.op1;
  assign operand2          = out_op.op2;
  assign out_illegal       = out_op.illegal;

  // Branch outcome and counters follow the out handshake even in a flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_valid    <= 1'b0;
      br_taken    <= 1'b0;
      issued_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      br_valid <= 1'b0;
      if (out_hs) begin
        issued_cnt <= issued_cnt + CNT_W'(1);
        if (out_op.illegal) illegal_cnt <= illegal_cnt + CNT_W'(1);
        if (out_op.is_beq || out_op.is_bne) begin
          br_valid <= 1'b1;
          br_taken <= out_op.is_beq ? zero : !zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small behavioural ALU supplying the zero flag.
// All checks run one time unit after a rising edge.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready;
  logic [1:0]       in_alu_op;
  logic [2:0]       in_funct3;
  logic             in_funct7_b5, in_is_rtype, in_alu_src;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_imm;
  logic             out_valid, out_ready;
  logic [3:0]       alu_control_lines;
  logic [XLEN-1:0]  operand1, operand2;
  logic             out_illegal, zero, br_valid, br_taken;
  logic [CNT_W-1:0] issued_cnt, illegal_cnt;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_is_rtype(in_is_rtype), .in_alu_src(in_alu_src),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control_lines(alu_control_lines), .operand1(operand1), .operand2(operand2),
    .out_illegal(out_illegal), .zero(zero),
    .br_valid(br_valid), .br_taken(br_taken),
    .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (alu_control_lines)
      4'b0000: alu_res = operand1 & operand2;
      4'b0001: alu_res = operand1 | operand2;
      4'b0010: alu_res = operand1 + operand2;
      4'b0110: alu_res = operand1 - operand2;
      default: alu_res = '0;
    endcase
  end
  assign zero = (alu_res == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic rt, input logic src, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm);
    in_valid     = 1'b1;
    in_alu_op    = op;
    in_funct3    = f3;
    in_funct7_b5 = f7;
    in_is_rtype  = rt;
    in_alu_src   = src;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_imm       = imm;
  endtask

  int sent, got;
  logic acc;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_code", 32'(alu_control_lines), 0);
    chk("rst_op1", operand1, 0);
    chk("rst_op2", operand2, 0);
    chk("rst_illegal", 32'(out_illegal), 0);
    chk("rst_br_valid", 32'(br_valid), 0);
    chk("rst_br_taken", 32'(br_taken), 0);
    chk("rst_issued", 32'(issued_cnt), 0);
    chk("rst_illcnt", 32'(illegal_cnt), 0);
    rst = 1'b0;

    // R-type SUB then I-type ADDI with identical funct bits
    drive(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 7, 7, 0);
    step();
    chk("sub_valid", 32'(out_valid), 1);
    chk("sub_code", 32'(alu_control_lines), 32'h6);
    chk("sub_op1", operand1, 7);
    chk("sub_op2", operand2, 7);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 7, 7, 5);
    step();
    chk("addi_code", 32'(alu_control_lines), 32'h2);
    chk("addi_op2", operand2, 5);
    in_valid = 1'b0;
    step();
    chk("idle_valid", 32'(out_valid), 0);
    chk("issued_2", 32'(issued_cnt), 2);

    // BEQ taken, BNE not taken
    drive(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 0);
    step();
    in_valid = 1'b0;
    chk("beq_code", 32'(alu_control_lines), 32'h6);
    chk("beq_pre_br", 32'(br_valid), 0);
    step();
    chk("beq_br_valid", 32'(br_valid), 1);
    chk("beq_taken", 32'(br_taken), 1);
    drive(2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234, 0);
    chk("beq_pulse_end", 32'(br_valid), 1);
    step();
    in_valid = 1'b0;
    chk("bne_pre_br", 32'(br_valid), 0);
    step();
    chk("bne_br_valid", 32'(br_valid), 1);
    chk("bne_taken", 32'(br_taken), 0);

    // Illegal R/I funct3
    drive(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 1, 2, 0);
    step();
    in_valid = 1'b0;
    chk("ill_code", 32'(alu_control_lines), 32'hF);
    chk("ill_flag", 32'(out_illegal), 1);
    step();
    chk("ill_cnt", 32'(illegal_cnt), 1);
    chk("ill_no_br", 32'(br_valid), 0);
    chk("issued_5", 32'(issued_cnt), 5);

    // Back-pressure: four ADDs, out_ready low for the first three cycles
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 3);
      if (sent < 4) drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'(11 + sent), 0, 0);
      else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (cyc == 2) begin
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_accepts", 32'(sent), 2);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", operand1, 32'(11 + got));
        got++;
      end
      step();
      if (acc) sent++;
    end
    chk("bp_got", 32'(got), 4);
    chk("bp_issued", 32'(issued_cnt), 9);

    // Flush with out (BEQ) and skid full, out handshake in the same cycle
    out_ready = 1'b0;
    drive(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h21, 32'h21, 0);
    step();
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h22, 0, 0);
    step();
    in_valid = 1'b0;
    chk("fl_skid_full", 32'(in_ready), 0);
    chk("fl_out_op", operand1, 32'h21);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    chk("fl_issued", 32'(issued_cnt), 10);
    chk("fl_br_valid", 32'(br_valid), 1);
    chk("fl_br_taken", 32'(br_taken), 1);
    repeat (3) begin
      step();
      chk("fl_skid_dropped", 32'(out_valid), 0);
    end
    chk("fl_issued_hold", 32'(issued_cnt), 10);

    // Reset mid-stream with both entries full
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h31, 0, 0);
    step();
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h32, 0, 0);
    step();
    in_valid = 1'b0;
    chk("mr_full", 32'(in_ready), 0);
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 0);
    chk("mr_in_ready", 32'(in_ready), 1);
    chk("mr_issued", 32'(issued_cnt), 0);
    chk("mr_illcnt", 32'(illegal_cnt), 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h55, 0, 0);
    chk("mr_pre_valid", 32'(out_valid), 0);
    step();
    in_valid = 1'b0;
    chk("mr_lat_valid", 32'(out_valid), 1);
    chk("mr_lat_op1", operand1, 32'h55);
    step();
    chk("mr_issued_1", 32'(issued_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Issue stage that drives the ALU's interface: decodes ALUOp/funct fields into the 4-bit ALU control code, selects the operands, and presents them registered to the ALU.
- Consumes the ALU's combinational zero flag on the cycle of issue and reports a registered branch decision (BEQ/BNE) one cycle later.
- Sits between decode (upstream valid/ready) and the ALU/EX consumer (downstream valid/ready).
- Uses a 2-entry skid buffer so a registered in_ready still sustains one op per cycle.

Parameters:
- XLEN, 32, datapath width of rs1/rs2/imm/operands.
- CNT_W, 16, width of the issued-op and illegal-op counters.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous; drops all buffered ops.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  upstream may transfer; registered.
- in_alu_op  input  2  00 load/store add, 01 branch sub, 10 R/I-type.
- in_funct3  input  3  instruction funct3.
- in_funct7_b5  input  1  instruction bit 30.
- in_is_rtype  input  1  1 = R-type (funct7_b5 selects SUB); 0 = I-type (bit ignored).
- in_alu_src  input  1  1 = operand2 from imm; 0 = from rs2.
- in_rs1  input  XLEN  register operand 1.
- in_rs2  input  XLEN  register operand 2.
- in_imm  input  XLEN  sign-extended immediate.
- out_valid  output  1  ALU inputs valid.
- out_ready  input  1  EX stage accepts the current op.
- alu_control_lines  output  4  ALU control code.
- operand1  output  XLEN  to the ALU.
- operand2  output  XLEN  to the ALU.
- out_illegal  output  1  current op had an unsupported encoding.
- zero  input  1  ALU zero flag, combinational from operand1/operand2/alu_control_lines.
- br_valid  output  1  one-cycle pulse: branch resolved.
- br_taken  output  1  branch outcome; meaningful only while br_valid=1.
- issued_cnt  output  CNT_W  count of completed output handshakes.
- illegal_cnt  output  CNT_W  count of completed handshakes with out_illegal=1.

Behaviour:
- Reset (async assert): out_valid=0, skid empty, in_ready=1, alu_control_lines=0, operand1=0, operand2=0, out_illegal=0, br_valid=0, br_taken=0, both counters=0. Reset during any operation discards all ops.
- Decode, combinational, applied at input capture:
  - alu_op 00 -> 0010 (ADD).
  - alu_op 01 -> 0110 (SUB).
  - alu_op 10, funct3 000 -> 0110 if in_is_rtype && funct7_b5, else 0010.
  - alu_op 10, funct3 111 -> 0000 (AND); funct3 110 -> 0001 (OR).
  - Anything else (other funct3 with alu_op 10, or alu_op 11) -> 1111 with illegal=1.
  - Branch ops (alu_op 01) also latch funct3 internally: 000 = BEQ, 001 = BNE, else illegal.
- Operand select: operand1 = rs1; operand2 = in_alu_src ? imm : rs2.
- Handshakes:
  - In handshake = in_valid && in_ready.
  - Out handshake = out_valid && out_ready.
  - Output registers hold stable while out_valid && !out_ready.
- Skid buffer, one op in each of out and skid:
  - Out stage empty, or out handshake this cycle: it loads from skid if skid is valid, else from the input if in handshake.
  - In handshake while the out stage is held: the op goes to skid.
  - Input and skid both loading in the same cycle is impossible; in_ready=0 whenever skid is valid.
  - in_ready next = !(skid valid next).
  - Latency: input to out_valid is 1 cycle. Throughput is 1 op/cycle while out_ready=1.
- Branch resolve, on an out handshake of a legal branch op:
  - Next cycle br_valid=1, br_taken = zero for BEQ, !zero for BNE.
  - No pulse for non-branch or illegal ops.
- Counters increment on out handshake and wrap modulo 2^CNT_W.
- flush:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - An in handshake in the flush cycle is discarded.
  - An out handshake in the flush cycle is completed: counters update and br_valid still pulses.
  - flush has priority over all loads.

Decomposition:
- Shared package alu_pkg: ALU code constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_ILL=1111; ALUOp constants; branch funct3 constants. The ALU itself uses the same package.
- One combinational sub-module, alu_ctrl_decode (alu_op, funct3, funct7_b5, is_rtype -> code, illegal, is_beq, is_bne), reusable by other stages.

Test Plan:
- Reset mid-stream with both entries full, rst=1 -> immediately out_valid=0, in_ready=1, counters 0; after release, the first op appears 1 cycle after its in handshake.
- R-type SUB, alu_op=10, funct3=000, funct7_b5=1, is_rtype=1, rs1=7, rs2=7 -> code 0110, operand1=7, operand2=7. I-type ADDI with the same bits, is_rtype=0, alu_src=1, imm=5 -> code 0010, operand2=5.
- BEQ rs1=rs2=0x1234 with the ALU model attached -> br_valid pulses 1 cycle after the out handshake, br_taken=1. BNE with the same operands -> br_taken=0.
- Back-pressure: stream of 4 ADDs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, no op lost or reordered, 4 handshakes total once out_ready=1, issued_cnt=4.
- Illegal: alu_op=10, funct3=100 -> code 1111, out_illegal=1, no br_valid, illegal_cnt increments by 1.
- flush with out and skid both valid and an out handshake the same cycle -> that op counted, next cycle out_valid=0, in_ready=1, the skid op never issued.
